ahfp_sub_align: RTL

- Multicycle operand-alignment stage that sits directly upstream of the floating-point subtractor's mantissa-subtract/normalise logic.
- Computes dataa - datab for IEEE-754 single precision:
  - Captures both operands on a start pulse.
  - Orders them by magnitude.
  - Right-shifts the smaller mantissa by the exponent difference, SHIFT_STEP bits per cycle, tracking guard/round/sticky.
  - Presents aligned mantissas, the common exponent, result sign and effective operation with a start/done handshake (custom-instruction multicycle style).

---
 rtl/ahfp_pkg.sv | 32 +++
 rtl/ahfp_sub_align_if.sv | 28 ++
 rtl/ahfp_unpack.sv | 45 ++++
 rtl/ahfp_sub_align.sv | 130 +++++++++++++
 4 files changed

// File: rtl/ahfp_pkg.sv
// Shared widths, constants and types for the single-precision subtract alignment stage.
package ahfp_pkg;

    localparam int MANT_W = 24;
    localparam int EXP_W = 8;
    localparam int EXT_W = 26;
    localparam int SHIFT_SAT = 26;
    localparam int CNT_W = 5;
    localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    typedef struct packed {
        logic [MANT_W-1:0] big_m;
        logic [MANT_W-1:0] small_m;
        logic [EXP_W-1:0]  exp_big;
        logic [CNT_W-1:0]  dsat;
        logic              sign;
        logic              eff_sub;
        logic              special;
    } unpack_t;

    // A zero exponent field denotes a denormal, whose true scale matches exponent 1.
    function automatic logic [EXP_W-1:0] eff_exp(input logic [EXP_W-1:0] e);
        return (e == '0) ? EXP_W'(1) : e;
    endfunction

endpackage

// File: rtl/ahfp_sub_align_if.sv
// Request/result bundle between the requester and the alignment stage.
interface ahfp_sub_align_if;
    import ahfp_pkg::*;

    logic              start;
    logic [31:0]       dataa;
    logic [31:0]       datab;
    logic              busy;
    logic              done;
    logic [MANT_W-1:0] big_m;
    logic [MANT_W-1:0] small_m;
    logic [2:0]        grs;
    logic [EXP_W-1:0]  exp_out;
    logic              sign_out;
    logic              eff_sub;
    logic              special;

    modport master (
        output start, dataa, datab,
        input  busy, done, big_m, small_m, grs, exp_out, sign_out, eff_sub, special
    );

    modport slave (
        input  start, dataa, datab,
        output busy, done, big_m, small_m, grs, exp_out, sign_out, eff_sub, special
    );

endinterface

// File: rtl/ahfp_unpack.sv
// Splits both operands, orders them by magnitude and derives the saturated
// exponent difference, result sign and effective operation.
module ahfp_unpack
    import ahfp_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output unpack_t     unp_o
);

    logic [EXP_W-1:0]  expA;
    logic [EXP_W-1:0]  expB;
    logic [EXP_W-1:0]  effA;
    logic [EXP_W-1:0]  effB;
    logic [EXP_W-1:0]  expBig;
    logic [EXP_W-1:0]  expSmall;
    logic [EXP_W-1:0]  diff;
    logic [MANT_W-1:0] mantA;
    logic [MANT_W-1:0] mantB;
    logic              swap;

    // Equal magnitudes keep dataa as the big operand, so a - a yields a's sign.
    always_comb begin
        expA     = a_i[30:23];
        expB     = b_i[30:23];
        effA     = eff_exp(expA);
        effB     = eff_exp(expB);
        mantA    = {expA != '0, a_i[22:0]};
        mantB    = {expB != '0, b_i[22:0]};
        swap     = (effB > effA) || ((effB == effA) && (mantB > mantA));
        expBig   = swap ? effB : effA;
        expSmall = swap ? effA : effB;
        diff     = expBig - expSmall;

        unp_o         = '0;
        unp_o.big_m   = swap ? mantB : mantA;
        unp_o.small_m = swap ? mantA : mantB;
        unp_o.exp_big = expBig;
        unp_o.dsat    = (diff >= EXP_W'(SHIFT_SAT)) ? CNT_W'(SHIFT_SAT) : diff[CNT_W-1:0];
        unp_o.sign    = swap ? ~b_i[31] : a_i[31];
        unp_o.eff_sub = (a_i[31] == b_i[31]);
        unp_o.special = (expA == EXP_SPECIAL) || (expB == EXP_SPECIAL);
    end

endmodule

// File: rtl/ahfp_sub_align.sv
// Multicycle operand alignment for a single-precision subtract: the smaller
// mantissa is right-shifted SHIFT_STEP bits per cycle with guard/round/sticky tracking.
module ahfp_sub_align
    import ahfp_pkg::*;
#(
    parameter int SHIFT_STEP = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            clk_en,
    ahfp_sub_align_if.slave bus
);

    if (!(SHIFT_STEP == 1 || SHIFT_STEP == 2 || SHIFT_STEP == 4 || SHIFT_STEP == 8)) begin : g_bad_step
        $error("ahfp_sub_align: SHIFT_STEP must be 1, 2, 4 or 8");
    end

    localparam logic [CNT_W-1:0] STEP = CNT_W'(SHIFT_STEP);

    unpack_t unp;

    ahfp_unpack u_unpack (
        .a_i   (bus.dataa),
        .b_i   (bus.datab),
        .unp_o (unp)
    );

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [CNT_W-1:0]  shAmt;
    logic [EXT_W-1:0]  sr_q;
    logic [EXT_W-1:0]  sr_d;
    logic [EXT_W-1:0]  lostMask;
    logic              sticky_q;
    logic              sticky_d;
    logic              busy_q;
    logic              done_q;
    logic              sign_q;
    logic              eff_sub_q;
    logic              special_q;
    logic [MANT_W-1:0] big_m_q;
    logic [MANT_W-1:0] small_m_q;
    logic [2:0]        grs_q;
    logic [EXP_W-1:0]  exp_q;

    // Bits falling off below R in this step are folded into sticky.
    always_comb begin
        shAmt    = (cnt_q < STEP) ? cnt_q : STEP;
        lostMask = (EXT_W'(1) << shAmt) - EXT_W'(1);
        sr_d     = sr_q >> shAmt;
        sticky_d = sticky_q | (|(sr_q & lostMask));
        cnt_d    = cnt_q - shAmt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sr_q      <= '0;
            sticky_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sign_q    <= 1'b0;
            eff_sub_q <= 1'b0;
            special_q <= 1'b0;
            big_m_q   <= '0;
            small_m_q <= '0;
            grs_q     <= '0;
            exp_q     <= '0;
        end else if (clk_en) begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        big_m_q   <= unp.big_m;
                        exp_q     <= unp.exp_big;
                        sign_q    <= unp.sign;
                        eff_sub_q <= unp.eff_sub;
                        special_q <= unp.special;
                        sr_q      <= {unp.small_m, 2'b00};
                        sticky_q  <= 1'b0;
                        cnt_q     <= unp.dsat;
                        busy_q    <= 1'b1;
                        // Equal exponents need no shifting, so the result is ready next cycle.
                        if (unp.dsat == '0) begin
                            state_q   <= DONE;
                            done_q    <= 1'b1;
                            small_m_q <= unp.small_m;
                            grs_q     <= '0;
                        end else begin
                            state_q <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    sr_q     <= sr_d;
                    sticky_q <= sticky_d;
                    cnt_q    <= cnt_d;
                    if (cnt_d == '0) begin
                        state_q   <= DONE;
                        done_q    <= 1'b1;
                        small_m_q <= sr_d[EXT_W-1:2];
                        grs_q     <= {sr_d[1:0], sticky_d};
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.big_m    = big_m_q;
    assign bus.small_m  = small_m_q;
    assign bus.grs      = grs_q;
    assign bus.exp_out  = exp_q;
    assign bus.sign_out = sign_q;
    assign bus.eff_sub  = eff_sub_q;
    assign bus.special  = special_q;

endmodule
